// File: rtl/dm_multihart.sv
// dm_multihart: RISC-V debug module for NUM_HART harts.
// Bridges the DMI (debug transport) to the core-side debug bus polled by the
// debug ROM. Tracks per-hart haltreq/halted/resumeack, abstract command errors
// and core-reported exceptions. ROM reads below ROM_SIZE go to an external ROM.
// Optional feature macro: DM_AUTOEXEC_EN (abstractauto autoexecdata support).
module dm_multihart #(
   parameter int unsigned NUM_HART   = 4,
   parameter int unsigned DATA_COUNT = 2,
   parameter int unsigned ROM_SIZE   = 'h200
) (
   input  logic                clk,
   input  logic                reset,
   output logic [NUM_HART-1:0] interrupt,
   input  logic                dmi_valid,
   output logic                dmi_ready,
   input  logic                dmi_write,
   input  logic [8:2]          dmi_addr,
   input  logic [31:0]         dmi_wdata,
   output logic [31:0]         dmi_rdata,
   input  logic                bus_valid,
   output logic                bus_ready,
   input  logic                bus_write,
   input  logic [19:0]         bus_addr,
   input  logic [31:0]         bus_wdata,
   output logic [31:0]         bus_rdata,
   output logic [9:0]          rom_addr,
   output logic [11:0]         rom_instr_fix,
   input  logic [31:0]         rom_rdata
);

   localparam int unsigned HW = (NUM_HART > 1) ? $clog2(NUM_HART) : 1;
   localparam int unsigned DW = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
   localparam logic [10:0] NH = 11'(NUM_HART);
   localparam logic [6:0]  DMI_DATA_END = 7'(4 + DATA_COUNT);
   localparam logic [5:0]  BUS_DATA_CNT = 6'(DATA_COUNT);

   // DMI word indices
   localparam logic [6:0] A_DMCONTROL   = 7'h10;
   localparam logic [6:0] A_DMSTATUS    = 7'h11;
   localparam logic [6:0] A_ABSTRACTCS  = 7'h16;
   localparam logic [6:0] A_COMMAND     = 7'h17;
   localparam logic [6:0] A_ABSTRACTAUT = 7'h18;

   // Debug bus byte addresses
   localparam logic [19:0] B_REQUEST   = 20'h00300;
   localparam logic [19:0] B_HALT      = 20'h00304;
   localparam logic [19:0] B_RESUME    = 20'h00308;
   localparam logic [19:0] B_EXCEPTION = 20'h0030C;

   // Request numbers
   localparam logic [4:0] R_RESUME  = 5'd1;
   localparam logic [4:0] R_GET_GPR = 5'd2;
   localparam logic [4:0] R_SET_GPR = 5'd3;
   localparam logic [4:0] R_GET_CSR = 5'd4;
   localparam logic [4:0] R_SET_CSR = 5'd5;
   localparam logic [4:0] R_GET_MEM = 5'd6;
   localparam logic [4:0] R_SET_MEM = 5'd7;

   // cmderr codes
   localparam logic [2:0] E_NONE       = 3'd0;
   localparam logic [2:0] E_BUSY       = 3'd1;
   localparam logic [2:0] E_NOTSUPP    = 3'd2;
   localparam logic [2:0] E_EXCEPTION  = 3'd3;
   localparam logic [2:0] E_HALTRESUME = 3'd4;

   typedef struct packed {
      logic [2:0]  err;
      logic        post;
      logic [31:0] req;
      logic [11:0] fix;
   } exec_t;

   logic [NUM_HART-1:0] haltreq;
   logic [NUM_HART-1:0] halted;
   logic [NUM_HART-1:0] resumeack;
   logic [9:0]          hartsel;
   logic                dmactive;
   logic [2:0]          cmderr;
   logic [31:0]         dm_request;
   logic [31:0]         data_q [DATA_COUNT];
`ifdef DM_AUTOEXEC_EN
   logic [DATA_COUNT-1:0] abstractauto;
   logic [31:0]           last_cmd;
`endif

   logic        dmi_match, bus_match;
   logic        busy;
   logic        sel_exists, sel_halted;
   logic        new_exists;
   logic [HW-1:0] new_idx;
   logic        dmi_data_hit;
   logic [6:0]  dmi_k;
   logic        bus_data_hit;
   logic [4:0]  bus_k;
   logic        bus_hart_ok;
   logic [HW-1:0] bus_hart;
   logic [31:0] dmi_rd_mux, bus_rd_mux, dmstatus;
   logic        dmactive_nxt;
   logic        do_exec;
   logic [31:0] exec_cmd;
   exec_t       exec_res;
   logic        unused_bits;

   // Abstract command checks in priority order; returns the error or request to post.
   function automatic exec_t run_cmd(input logic [31:0] cmd, input logic [2:0] err_cur,
                                     input logic is_busy, input logic halted_sel,
                                     input logic [9:0] hs);
      exec_t r;
      logic [4:0] num;
      r   = '0;
      num = '0;
      if (err_cur != E_NONE) begin
         r.err = E_NONE;
      end else if (is_busy) begin
         r.err = E_BUSY;
      end else if (!halted_sel) begin
         r.err = E_HALTRESUME;
      end else if (cmd[31:24] == 8'd0) begin
         if (cmd[22:20] != 3'd2) begin
            r.err = E_EXCEPTION;
         end else if (cmd[17]) begin
            if (cmd[15:0] >= 16'h1020) begin
               r.err = E_NOTSUPP;
            end else if (cmd[15:0] >= 16'h1000) begin
               num    = cmd[16] ? R_SET_GPR : R_GET_GPR;
               r.post = 1'b1;
               r.fix  = {7'd0, cmd[4:0]};
            end else begin
               num    = cmd[16] ? R_SET_CSR : R_GET_CSR;
               r.post = 1'b1;
               r.fix  = cmd[11:0];
            end
         end
      end else if (cmd[31:24] == 8'd2) begin
         num    = cmd[16] ? R_SET_MEM : R_GET_MEM;
         r.post = 1'b1;
         r.fix  = {9'd0, cmd[22:20]};
      end else begin
         r.err = E_NOTSUPP;
      end
      r.req = {1'b1, 10'd0, num, 6'd0, hs};
      return r;
   endfunction

   assign interrupt   = haltreq;
   assign rom_addr    = bus_addr[9:0];
   assign unused_bits = ^{dmi_wdata, bus_wdata, bus_addr};

   // Decode, status assembly and read muxes for both ports.
   always_comb begin
      dmi_match    = dmi_valid && dmi_ready;
      bus_match    = bus_valid && bus_ready;
      busy         = dm_request[31];
      sel_exists   = {1'b0, hartsel} < NH;
      sel_halted   = sel_exists && halted[hartsel[HW-1:0]];
      new_exists   = {1'b0, dmi_wdata[25:16]} < NH;
      new_idx      = dmi_wdata[16 +: HW];
      dmi_data_hit = (dmi_addr >= 7'h04) && (dmi_addr < DMI_DATA_END);
      dmi_k        = dmi_addr - 7'h04;
      bus_data_hit = (bus_addr[19:7] == 13'h0007) && ({1'b0, bus_addr[6:2]} < BUS_DATA_CNT);
      bus_k        = bus_addr[6:2];
      bus_hart_ok  = bus_wdata < NUM_HART;
      bus_hart     = bus_wdata[HW-1:0];

      dmstatus = '0;
      if (!sel_exists) begin
         dmstatus[15:14] = 2'b11;
      end else begin
         dmstatus[17:16] = {2{resumeack[hartsel[HW-1:0]]}};
         dmstatus[11:10] = {2{!halted[hartsel[HW-1:0]]}};
         dmstatus[9:8]   = {2{halted[hartsel[HW-1:0]]}};
      end
      dmstatus[3:0] = 4'd2;

      dmi_rd_mux = '0;
      case (dmi_addr)
         A_DMCONTROL:  dmi_rd_mux = {sel_exists && haltreq[hartsel[HW-1:0]], 5'd0, hartsel,
                                     15'd0, dmactive};
         A_DMSTATUS:   dmi_rd_mux = dmstatus;
         A_ABSTRACTCS: dmi_rd_mux = {8'd0, 11'd0, busy, 1'b0, cmderr, 4'd0, 4'(DATA_COUNT)};
`ifdef DM_AUTOEXEC_EN
         A_ABSTRACTAUT: dmi_rd_mux = 32'(abstractauto);
`endif
         default: if (dmi_data_hit) dmi_rd_mux = data_q[dmi_k[DW-1:0]];
      endcase

      bus_rd_mux = '0;
      if (bus_addr < 20'(ROM_SIZE))  bus_rd_mux = rom_rdata;
      else if (bus_addr == B_REQUEST) bus_rd_mux = dm_request;
      else if (bus_data_hit)          bus_rd_mux = data_q[bus_k[DW-1:0]];

      dmactive_nxt = (dmi_match && dmi_write && dmi_addr == A_DMCONTROL) ? dmi_wdata[0] : dmactive;

`ifdef DM_AUTOEXEC_EN
      exec_cmd = (dmi_write && dmi_addr == A_COMMAND) ? dmi_wdata : last_cmd;
      do_exec  = dmi_match && ((dmi_write && dmi_addr == A_COMMAND) ||
                               (dmi_data_hit && abstractauto[dmi_k[DW-1:0]]));
`else
      exec_cmd = dmi_wdata;
      do_exec  = dmi_match && dmi_write && dmi_addr == A_COMMAND;
`endif
      exec_res = run_cmd(exec_cmd, cmderr, busy, sel_halted, hartsel);
   end

   // Handshakes, read data and all DM state; later assignments win, so the bus
   // side is applied first and the DMI side overrides it on the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         dmi_ready     <= 1'b0;
         dmi_rdata     <= '0;
         bus_ready     <= 1'b0;
         bus_rdata     <= '0;
         rom_instr_fix <= '0;
         haltreq       <= '0;
         halted        <= '0;
         resumeack     <= '0;
         hartsel       <= '0;
         dmactive      <= 1'b0;
         cmderr        <= '0;
         dm_request    <= '0;
         for (int unsigned i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
`ifdef DM_AUTOEXEC_EN
         abstractauto  <= '0;
         last_cmd      <= '0;
`endif
      end else begin
         dmi_ready <= dmi_valid && !dmi_ready;
         bus_ready <= bus_valid && !bus_ready;
         if (dmi_valid && !dmi_write) dmi_rdata <= dmi_rd_mux;
         if (bus_valid && !bus_write) bus_rdata <= bus_rd_mux;

         if (bus_match && bus_write) begin
            if (bus_addr == B_REQUEST) dm_request <= '0;
            if (bus_addr == B_HALT && bus_hart_ok) halted[bus_hart] <= 1'b1;
            if (bus_addr == B_RESUME && bus_hart_ok) begin
               halted[bus_hart]    <= 1'b0;
               resumeack[bus_hart] <= 1'b1;
            end
            if (bus_addr == B_EXCEPTION) begin
               if (cmderr == E_NONE) cmderr <= E_EXCEPTION;
               dm_request <= '0;
            end
            if (bus_data_hit) data_q[bus_k[DW-1:0]] <= bus_wdata;
         end

         if (dmi_match && dmi_write) begin
            case (dmi_addr)
               A_DMCONTROL: begin
                  dmactive <= dmi_wdata[0];
                  hartsel  <= dmi_wdata[25:16];
                  if (new_exists) begin
                     haltreq[new_idx] <= dmi_wdata[31];
                     if (dmi_wdata[30] && halted[new_idx]) begin
                        resumeack[new_idx] <= 1'b0;
                        dm_request <= {1'b1, 10'd0, R_RESUME, 6'd0, dmi_wdata[25:16]};
                     end
                  end
               end
               A_ABSTRACTCS: cmderr <= cmderr & ~dmi_wdata[10:8];
`ifdef DM_AUTOEXEC_EN
               A_COMMAND:     last_cmd <= dmi_wdata;
               A_ABSTRACTAUT: abstractauto <= dmi_wdata[DATA_COUNT-1:0];
`endif
               default: if (dmi_data_hit) data_q[dmi_k[DW-1:0]] <= dmi_wdata;
            endcase
         end

         if (do_exec) begin
            if (exec_res.err != E_NONE) cmderr <= exec_res.err;
            if (exec_res.post) begin
               dm_request    <= exec_res.req;
               rom_instr_fix <= exec_res.fix;
            end
         end

         // Inactive DM holds its control state cleared; data registers survive.
         if (!dmactive_nxt) begin
            haltreq    <= '0;
            hartsel    <= '0;
            cmderr     <= '0;
            dm_request <= '0;
`ifdef DM_AUTOEXEC_EN
            abstractauto <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_dm_multihart.sv
// tb_dm_multihart: directed scoreboard bench for dm_multihart (NUM_HART=4, DATA_COUNT=2).
module tb_dm_multihart;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  interrupt;
   logic        dmi_valid, dmi_ready, dmi_write;
   logic [8:2]  dmi_addr;
   logic [31:0] dmi_wdata, dmi_rdata;
   logic        bus_valid, bus_ready, bus_write;
   logic [19:0] bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   logic [9:0]  rom_addr;
   logic [11:0] rom_instr_fix;
   logic [31:0] rom_rdata;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   dm_multihart #(.NUM_HART(4), .DATA_COUNT(2), .ROM_SIZE('h200)) dut (
      .clk(clk), .reset(reset), .interrupt(interrupt),
      .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
      .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .rom_addr(rom_addr), .rom_instr_fix(rom_instr_fix), .rom_rdata(rom_rdata)
   );

   always #5 clk = ~clk;

   // External ROM model: recognisable pattern keyed by address
   assign rom_rdata = 32'hDEAD0000 | {22'd0, rom_addr};

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic dmi_xfer(input logic wr, input logic [6:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
      int unsigned n = 0;
      @(negedge clk);
      dmi_valid = 1'b1; dmi_write = wr; dmi_addr = a; dmi_wdata = d;
      do begin @(negedge clk); n++; end while (!dmi_ready && n < 20);
      rd = dmi_rdata;
      if (!dmi_ready) chk("dmi_timeout", 32'd0, 32'd1);
      else begin @(posedge clk); #1; end
      dmi_valid = 1'b0; dmi_write = 1'b0;
   endtask

   task automatic bus_xfer(input logic wr, input logic [19:0] a, input logic [31:0] d,
                           output logic [31:0] rd);
      int unsigned n = 0;
      @(negedge clk);
      bus_valid = 1'b1; bus_write = wr; bus_addr = a; bus_wdata = d;
      do begin @(negedge clk); n++; end while (!bus_ready && n < 20);
      rd = bus_rdata;
      if (!bus_ready) chk("bus_timeout", 32'd0, 32'd1);
      else begin @(posedge clk); #1; end
      bus_valid = 1'b0; bus_write = 1'b0;
   endtask

   task automatic dmi_wr(input logic [6:0] a, input logic [31:0] d);
      logic [31:0] rd;
      dmi_xfer(1'b1, a, d, rd);
   endtask

   task automatic bus_wr(input logic [19:0] a, input logic [31:0] d);
      logic [31:0] rd;
      bus_xfer(1'b1, a, d, rd);
   endtask

   // Scoreboarded reads: expectation queued at issue, popped when data returns
   task automatic dmi_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      exp_q.push_back(exp); tag_q.push_back(tag);
      dmi_xfer(1'b0, a, 32'd0, rd);
      chk(tag_q.pop_front(), rd, exp_q.pop_front());
   endtask

   task automatic bus_rd(input string tag, input logic [19:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      exp_q.push_back(exp); tag_q.push_back(tag);
      bus_xfer(1'b0, a, 32'd0, rd);
      chk(tag_q.pop_front(), rd, exp_q.pop_front());
   endtask

   initial begin
      int unsigned n;
      reset = 1'b1;
      dmi_valid = 0; dmi_write = 0; dmi_addr = '0; dmi_wdata = '0;
      bus_valid = 0; bus_write = 0; bus_addr = '0; bus_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_interrupt", 32'(interrupt), 32'd0);
      chk("rst_dmi_ready", 32'(dmi_ready), 32'd0);
      chk("rst_bus_ready", 32'(bus_ready), 32'd0);
      chk("rst_dmi_rdata", dmi_rdata, 32'd0);
      chk("rst_bus_rdata", bus_rdata, 32'd0);
      chk("rst_instr_fix", 32'(rom_instr_fix), 32'd0);
      reset = 1'b0;

      // 1: abstractcs after reset
      dmi_rd("abstractcs_rst", 7'h16, 32'h0000_0002);

      // 2: haltreq hart 0, core reports halt
      dmi_wr(7'h10, 32'h8000_0001);
      chk("interrupt_h0", 32'(interrupt), 32'h1);
      bus_wr(20'h304, 32'd0);
      dmi_rd("dmstatus_h0_halted", 7'h11, 32'h0000_0302);

      // 3: abstract commands on hart 0
      dmi_wr(7'h17, 32'h0022_1008);
      bus_rd("req_get_gpr", 20'h300, 32'h8002_0000);
      chk("instr_fix_gpr", 32'(rom_instr_fix), 32'h8);
      dmi_rd("abstractcs_busy", 7'h16, 32'h0000_1002);
      dmi_wr(7'h17, 32'h0022_1008);
      dmi_rd("cmderr_busy", 7'h16, 32'h0000_1102);
      dmi_wr(7'h16, 32'h0000_0700);
      dmi_rd("cmderr_w1c", 7'h16, 32'h0000_1002);
      bus_wr(20'h300, 32'd0);
      dmi_rd("req_cleared", 7'h16, 32'h0000_0002);

      dmi_wr(7'h17, 32'h0023_0300);
      bus_rd("req_set_csr", 20'h300, 32'h8005_0000);
      chk("instr_fix_csr", 32'(rom_instr_fix), 32'h300);
      bus_wr(20'h300, 32'd0);
      dmi_wr(7'h17, 32'h0022_1020);
      dmi_rd("cmderr_regno_range", 7'h16, 32'h0000_0202);
      bus_wr(20'h30C, 32'd0);
      dmi_rd("cmderr_sticky", 7'h16, 32'h0000_0202);
      dmi_wr(7'h16, 32'h0000_0700);
      dmi_wr(7'h17, 32'h0032_1000);
      dmi_rd("cmderr_aarsize", 7'h16, 32'h0000_0302);
      dmi_wr(7'h16, 32'h0000_0700);
      dmi_wr(7'h17, 32'h0100_0000);
      dmi_rd("cmderr_cmdtype", 7'h16, 32'h0000_0202);
      dmi_wr(7'h16, 32'h0000_0700);
      dmi_wr(7'h17, 32'h0020_1000);
      dmi_rd("no_transfer_cs", 7'h16, 32'h0000_0002);
      bus_rd("no_transfer_req", 20'h300, 32'h0000_0000);
      dmi_wr(7'h17, 32'h0230_0000);
      bus_rd("req_get_mem", 20'h300, 32'h8006_0000);
      chk("instr_fix_mem", 32'(rom_instr_fix), 32'h3);
      bus_wr(20'h30C, 32'd0);
      dmi_rd("cmderr_core_exc", 7'h16, 32'h0000_0302);
      bus_rd("exc_clears_req", 20'h300, 32'h0000_0000);
      dmi_wr(7'h16, 32'h0000_0700);

      // 4: nonexistent hart
      dmi_wr(7'h10, 32'h0005_0001);
      chk("interrupt_nonexist", 32'(interrupt), 32'h1);
      dmi_rd("dmstatus_nonexist", 7'h11, 32'h0000_C002);
      dmi_wr(7'h17, 32'h0022_1008);
      dmi_rd("cmderr_haltresume", 7'h16, 32'h0000_0402);
      dmi_wr(7'h16, 32'h0000_0700);

      // 5: resume hart 1
      dmi_wr(7'h10, 32'h0001_0001);
      chk("interrupt_h1_sel", 32'(interrupt), 32'h1);
      bus_wr(20'h304, 32'd1);
      dmi_rd("dmstatus_h1_halted", 7'h11, 32'h0000_0302);
      dmi_wr(7'h10, 32'h4001_0001);
      bus_rd("req_resume", 20'h300, 32'h8001_0001);
      bus_wr(20'h308, 32'd1);
      dmi_rd("dmstatus_resumeack", 7'h11, 32'h0003_0C02);
      bus_wr(20'h300, 32'd0);
      dmi_wr(7'h10, 32'h4001_0001);
      bus_rd("resume_running_ignored", 20'h300, 32'h0000_0000);

      // 6: same-cycle data0 writes, DMI wins
      @(negedge clk);
      dmi_valid = 1; dmi_write = 1; dmi_addr = 7'h04; dmi_wdata = 32'h0000_AAAA;
      bus_valid = 1; bus_write = 1; bus_addr = 20'h380; bus_wdata = 32'h0000_5555;
      n = 0;
      do begin @(negedge clk); n++; end while (!(dmi_ready && bus_ready) && n < 20);
      if (!(dmi_ready && bus_ready)) chk("dual_timeout", 32'd0, 32'd1);
      else begin @(posedge clk); #1; end
      dmi_valid = 0; dmi_write = 0; bus_valid = 0; bus_write = 0;
      dmi_rd("data0_dmi_wins", 7'h04, 32'h0000_AAAA);
      bus_rd("data0_bus_view", 20'h380, 32'h0000_AAAA);
      bus_wr(20'h384, 32'h0000_1234);
      dmi_rd("data1_from_bus", 7'h05, 32'h0000_1234);
      dmi_rd("data_beyond_count", 7'h06, 32'h0000_0000);
      bus_rd("rom_read", 20'h010, 32'hDEAD_0010);
      bus_rd("unmapped_bus", 20'h320, 32'h0000_0000);

      dmi_wr(7'h10, 32'h0000_0001);
      chk("interrupt_cleared", 32'(interrupt), 32'h0);
`ifdef DM_AUTOEXEC_EN
      dmi_wr(7'h17, 32'h0022_1008);
      bus_rd("autoexec_first", 20'h300, 32'h8002_0000);
      bus_wr(20'h300, 32'd0);
      dmi_wr(7'h18, 32'h0000_0001);
      dmi_rd("abstractauto_rd", 7'h18, 32'h0000_0001);
      dmi_rd("autoexec_data0", 7'h04, 32'h0000_AAAA);
      bus_rd("autoexec_repost", 20'h300, 32'h8002_0000);
      dmi_rd("autoexec_data0_busy", 7'h04, 32'h0000_AAAA);
      dmi_rd("autoexec_busy_err", 7'h16, 32'h0000_1102);
      bus_wr(20'h300, 32'd0);
      dmi_wr(7'h16, 32'h0000_0700);
`else
      dmi_wr(7'h18, 32'h0000_0001);
      dmi_rd("abstractauto_rd", 7'h18, 32'h0000_0000);
      dmi_rd("data0_no_autoexec", 7'h04, 32'h0000_AAAA);
      bus_rd("no_autoexec_req", 20'h300, 32'h0000_0000);
`endif

      // 7: dmactive = 0 clears control state but keeps data
      dmi_wr(7'h17, 32'h0100_0000);
      dmi_rd("cmderr_pre_deact", 7'h16, 32'h0000_0202);
      dmi_wr(7'h10, 32'h0000_0000);
      dmi_rd("deact_cmderr", 7'h16, 32'h0000_0002);
      dmi_rd("deact_abstractauto", 7'h18, 32'h0000_0000);
      dmi_rd("deact_data_kept", 7'h04, 32'h0000_AAAA);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_multihart.md
Name: dm_multihart

Overview:
- Next-generation RISC-V debug module supporting NUM_HART harts and a configurable number of abstract data registers.
- Sits between the DMI (debug transport side) and the core-facing debug bus polled by the debug ROM.
- Adds per-hart haltreq, halted and resumeack tracking, a full cmderr set (busy / not-supported / exception / halt-resume), and core-reported exceptions.
- ROM contents live outside the block: bus reads below ROM_SIZE are forwarded to an external ROM.

Parameters:
NUM_HART, 4, number of harts (1..1024); hart index width HW = max(1, clog2(NUM_HART))
DATA_COUNT, 2, number of abstract data registers data0..data(DATA_COUNT-1) (1..12)
ROM_SIZE, 'h200, bus byte addresses below this are ROM reads

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
interrupt  out  NUM_HART  per-hart debug interrupt, equals the haltreq vector
dmi_valid  in  1  DMI request valid
dmi_ready  out  1  DMI handshake ready
dmi_write  in  1  1 = write, 0 = read
dmi_addr  in  [8:2]  DMI word index
dmi_wdata  in  32  DMI write data
dmi_rdata  out  32  DMI read data
bus_valid  in  1  debug bus request valid
bus_ready  out  1  debug bus ready
bus_write  in  1  1 = write, 0 = read
bus_addr  in  20  debug bus byte address
bus_wdata  in  32  debug bus write data
bus_rdata  out  32  debug bus read data
rom_addr  out  10  equals bus_addr[9:0]
rom_instr_fix  out  12  instruction patch field driven to the external ROM
rom_rdata  in  32  combinational ROM data

Behaviour:
- Reset: all outputs 0; every internal register 0.
- Handshake, DMI and bus independently: ready rises the cycle after valid is seen; match = valid && ready. Ready drops the cycle after a match, giving one transfer per 2 cycles. Read data is registered on every valid non-write cycle and is therefore stable at match. Writes take effect at match.
- DMI map (word index):
  - 0x04+k: data k. Indices at or beyond DATA_COUNT read 0.
  - 0x10 dmcontrol: [31] haltreq, [30] resumereq, [25:16] hartsello, [0] dmactive.
  - 0x11 dmstatus: [17:16] allresumeack/anyresumeack, [11:10] allrunning/anyrunning, [9:8] allhalted/anyhalted, [15:14] allnonexistent/anynonexistent (set when hartsel >= NUM_HART; all other status bits read 0 in that case), [3:0] version = 2.
  - 0x16 abstractcs: [28:24] progbufsize = 0, [12] busy, [10:8] cmderr, [3:0] DATA_COUNT.
  - 0x17 command: write only.
  - 0x18 abstractauto.
  - All other indices read 0; writes to them are ignored.
- dmactive = 0: clears haltreq vector, hartsel, cmderr, dm_request and abstractauto. Data registers are kept. A dmcontrol write updates haltreq[hartsel_new] and hartsel in the same cycle.
- resumereq = 1 to a halted, existent hart: clears resumeack[hartsel] and posts request RESUME. Ignored if the hart is running or nonexistent.
- dm_request word: [31] valid, [20:16] number, [9:0] hartsel. Numbers: RESUME=1, GET_GPR=2, SET_GPR=3, GET_CSR=4, SET_CSR=5, GET_MEM=6, SET_MEM=7. busy = dm_request[31].
- Command write, checks in priority order:
  1. cmderr != 0: ignored.
  2. busy: cmderr = 1 (BUSY).
  3. Selected hart not halted: cmderr = 4 (HALTRESUME).
  4. cmdtype not 0 (accessreg) or 2 (accessmem): cmderr = 2 (NOTSUPPORTED).
  5. accessreg with aarsize != 2: cmderr = 3 (EXCEPTION).
  6. accessreg with transfer = 0: no request, no error.
  7. Otherwise post the request. regno 0x1000..0x101F is GPR (instr_fix = regno[4:0]); regno < 0x1000 is CSR (instr_fix = regno[11:0]); regno >= 0x1020 gives cmderr = 2. accessmem: instr_fix = aamsize [22:20] zero-extended.
- cmderr is sticky: a new error never overwrites a nonzero value. Writing abstractcs with bits [10:8] set clears the matching bits (W1C).
- Bus map:
  - 0x300 DM_REQUEST: read returns dm_request; write clears it.
  - 0x304 CORE_HALT: wdata = hart id; sets halted[id].
  - 0x308 CORE_RESUME: clears halted[id] and sets resumeack[id].
  - 0x30C CORE_EXCEPTION: cmderr = 3 if currently 0; clears dm_request.
  - 0x380+4k: data k.
  - Writes with hart id >= NUM_HART are ignored.
- Simultaneous DMI and bus writes to the same data register in one cycle: DMI wins.
- A bus clear of dm_request in the same cycle as a DMI command write: the command takes priority (it already sees busy and flags BUSY, so no overlap).

Optional Feature:
DM_AUTOEXEC_EN:
- Defined: abstractauto[DATA_COUNT-1:0] is autoexecdata. A DMI read or write of data k with bit k set re-executes the last accepted command through the full check sequence, including busy → cmderr 1.
- Undefined: abstractauto reads 0 and writes are ignored.

Test Plan:
1. Reset high 2 cycles, then DMI read 0x16 → rdata 0x0000_0002 (DATA_COUNT=2), busy 0.
2. Write dmcontrol 0x8000_0001; interrupt = 4'b0001. Bus write 0x304 = 0 → dmstatus reads 0x0000_0302.
3. Hart 0 halted, command 0x0022_1008 → bus read 0x300 = 0x8002_0000 (GET_GPR), rom_instr_fix = 8. A second command before the bus clear → cmderr 1. Write abstractcs 0x700 → cmderr 0.
4. hartsel = 5 with NUM_HART = 4 → dmstatus anynonexistent = 1, allhalted = 0. A command sets cmderr 4.
5. Hart 1 halted, resumereq 0x4001_0001 → request 0x8001_0001. Bus write 0x308 = 1 → allresumeack = 1, allrunning = 1.
6. Same-cycle DMI and bus writes to data0 (0xAAAA vs 0x5555) → data0 = 0xAAAA. With DM_AUTOEXEC_EN, abstractauto = 1 and a data0 read re-posts the last command.
